ob_rsp_egress: RTL
==================

Name: ob_rsp_egress

Overview:
- Response-side egress serializer for the order book: takes one packed response word (uid, status, result) per handshake and emits it as a fixed-length byte frame on an 8-bit valid/accept stream toward the host link.
- It is the transmit counterpart of the command-ingress path: the engine core produces responses, and this block frames them for the host.
- It sits between the engine response port and the link MAC or UART shim.

Parameters:
- HDR_TAG, 5'b10100, constant placed in byte0[7:3] of every frame; used by the host for frame sync.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- rsp_vld  in  1  response word valid.
- rsp  in  $bits(rsp_t) (115)  response: uid 32b, status 3b, result 80b.
- rsp_accept  out  1  block takes rsp this cycle when rsp_vld is high.
- out_vld  out  1  byte valid.
- out_data  out  8  frame byte.
- out_sop  out  1  first byte of frame.
- out_eop  out  1  last byte of frame.
- out_accept  in  1  downstream takes byte this cycle when out_vld is high.
- busy_r  out  1  a frame is held or in flight.
- frames_sent_r  out  16  count of completed frames; wraps 0xFFFF->0.

Behaviour:
- Reset values:
  - out_vld=0, out_sop=0, out_eop=0, out_data=0.
  - busy_r=0, frames_sent_r=0.
  - holding register cleared; FSM=IDLE; byte index=0.
- FSM states:
  - IDLE: rsp_accept=1. On rsp_vld, latch rsp into the holding register and go to SEND with index 0.
  - SEND: drive byte[index]. On out_vld&&out_accept: if the byte is the last byte, increment frames_sent_r and either reload or go to IDLE (see back-to-back below); otherwise increment index.
- Frame layout:
  - byte0 = {HDR_TAG, status}.
  - bytes1..4 = uid, MSB first.
  - bytes5..14 = result[79:0], MSB first.
  - byte15 = checksum (see Optional Feature).
- Latency: response accepted in cycle N; byte0 valid at N+1 (registered outputs, no combinational path from rsp to out_*).
- Output stability: while out_vld=1 and out_accept=0, out_data/out_sop/out_eop must hold; out_vld must not drop.
- Back-to-back:
  - In SEND, rsp_accept=1 only in the cycle the last byte is accepted (out_accept=1).
  - If rsp_vld is also high that cycle, the new rsp is latched and byte0 of the next frame is valid the following cycle. Zero bubble cycles.
- Pipeline depth: rsp_accept never asserts combinationally from out_accept except in the last-byte case above. Maximum one response held.
- busy_r: 1 from the cycle after accept until the cycle after the last-byte accept with no new rsp.
- Status field: passed verbatim; no opcode interpretation. The union is serialized raw.
- Reset mid-frame: frame abandoned immediately; no eop emitted; holding contents discarded.
- frames_sent_r: wraps silently.

Optional Feature:
- Macro: OB_RSP_EGRESS_CHECKSUM_EN.
- Defined: frame is 16 bytes. byte15 = XOR of bytes0..14, accumulated per byte as each is accepted. out_eop is on byte15.
- Undefined: frame is 15 bytes; out_eop is on byte14; no checksum logic.

Decomposition:
- ob_pkg gains:
  - RSP_FRAME_HDR_TAG default constant.
  - RSP_FRAME_BYTES_N (15/16 under the macro).
  - typedef rsp_frame_idx_t, logic [3:0].
- rsp_t and status_t are reused unchanged from ob_pkg.
- One natural sub-module: ob_rsp_egress_mux, a combinational byte select from the holding register by index. The FSM, counters and checksum stay in the top.

Test Plan:
- Single frame, out_accept tied 1: rsp uid=0x01020304, status=S_Okay, result=80'h0A0B..13 → bytes A0,01,02,03,04,0A..13 (+ checksum byte with the macro); sop on byte0, eop on last byte; frames_sent_r=1.
- Backpressure: toggle out_accept 1010… through a S_CancelHit (status 3'b010) frame → byte0=0xA2; out_data held on stalled cycles; the byte sequence is identical to the unstalled frame.
- Back-to-back: two rsp with rsp_vld held high → second byte0 appears in the cycle immediately after the first eop accept; rsp_accept pulses exactly twice.
- Checksum (macro on): rsp with all-zero uid/result, status=S_Bad → byte0=0xA4, bytes1..14=0, byte15=0xA4.
- Reset mid-frame: assert rst after byte6 accept → out_vld=0 the same cycle (async); after release, the next rsp starts a fresh frame with sop; frames_sent_r=0.
- Counter wrap: preload by sending 65536 frames (or force) → frames_sent_r rolls from 0xFFFF to 0x0000.

Source files
------------

// File: rtl/ob_rsp_egress_pkg.sv
// ob_rsp_egress_pkg: shared types and constants for the response egress path.
// Build option OB_RSP_EGRESS_CHECKSUM_EN selects the 16-byte checksummed frame.
package ob_rsp_egress_pkg;

  // Frame sync tag carried in byte0[7:3] of every frame.
  localparam logic [4:0] RSP_FRAME_HDR_TAG = 5'b10100;

`ifdef OB_RSP_EGRESS_CHECKSUM_EN
  localparam int RSP_FRAME_BYTES_N = 16;
`else
  localparam int RSP_FRAME_BYTES_N = 15;
`endif

  typedef logic [3:0] rsp_frame_idx_t;

  localparam rsp_frame_idx_t RSP_FRAME_LAST_IDX = rsp_frame_idx_t'(RSP_FRAME_BYTES_N - 1);

  // Response status; serialized raw, never interpreted here.
  typedef enum logic [2:0] {
    S_Okay       = 3'b000,
    S_Fill       = 3'b001,
    S_CancelHit  = 3'b010,
    S_CancelMiss = 3'b011,
    S_Bad        = 3'b100,
    S_Rsv5       = 3'b101,
    S_Rsv6       = 3'b110,
    S_Rsv7       = 3'b111
  } status_t;

  typedef struct packed {
    logic [31:0] uid;
    status_t     status;
    logic [79:0] result;
  } rsp_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } egress_state_t;

endpackage

// File: rtl/ob_rsp_egress_if.sv
// ob_rsp_egress_if: response-in / byte-stream-out handshake bundle.
// master = engine/link side, slave = egress serializer.
interface ob_rsp_egress_if;
  import ob_rsp_egress_pkg::*;

  logic       rsp_vld;
  rsp_t       rsp;
  logic       rsp_accept;
  logic       out_vld;
  logic [7:0] out_data;
  logic       out_sop;
  logic       out_eop;
  logic       out_accept;

  modport master (
    output rsp_vld, rsp, out_accept,
    input  rsp_accept, out_vld, out_data, out_sop, out_eop
  );

  modport slave (
    input  rsp_vld, rsp, out_accept,
    output rsp_accept, out_vld, out_data, out_sop, out_eop
  );

endinterface

// File: rtl/ob_rsp_egress_mux.sv
// ob_rsp_egress_mux: selects frame byte [idx] from the held response.
// Covers the header, uid and result bytes; indices past them yield zero.
module ob_rsp_egress_mux
  import ob_rsp_egress_pkg::*;
#(
  parameter logic [4:0] HDR_TAG = RSP_FRAME_HDR_TAG
) (
  input  rsp_t           hold,
  input  rsp_frame_idx_t idx,
  output logic [7:0]     frame_byte
);

  // Header, uid and result laid out MSB first, byte0 in the top bits.
  logic [119:0] frame;

  assign frame = {HDR_TAG, hold.status, hold.uid, hold.result};

  // Byte select by index.
  always_comb begin
    // NOTE: default first so every index path assigns frame_byte and no latch is inferred.
    frame_byte = 8'h00;
    for (int i = 0; i < 15; i++) begin
      if (idx == rsp_frame_idx_t'(i)) frame_byte = frame[119 - 8*i -: 8];
    end
  end

endmodule

// File: rtl/ob_rsp_egress.sv
// ob_rsp_egress: serializes one response word per handshake into a byte frame.
// Define OB_RSP_EGRESS_CHECKSUM_EN to append an XOR checksum byte (16-byte frame);
// otherwise the frame is 15 bytes with no checksum.
module ob_rsp_egress
  import ob_rsp_egress_pkg::*;
#(
  parameter logic [4:0] HDR_TAG = RSP_FRAME_HDR_TAG
) (
  input  logic           clk,
  input  logic           rst,
  ob_rsp_egress_if.slave bus,
  output logic           busy_r,
  output logic [15:0]    frames_sent_r
);

  egress_state_t  state_q, state_d;
  rsp_frame_idx_t idx_q, idx_d;
  rsp_t           hold_q;
  logic           load;
  logic           last_acc;
  logic           rsp_accept;
  logic           out_vld;
  logic           byte_acc;
  logic [7:0]     mux_byte;
  logic [7:0]     frame_byte;

  ob_rsp_egress_mux #(.HDR_TAG(HDR_TAG)) u_mux (
    .hold       (hold_q),
    .idx        (idx_q),
    .frame_byte (mux_byte)
  );

  assign out_vld  = (state_q == ST_SEND);
  assign byte_acc = out_vld && bus.out_accept;

  // Next state, byte index and response-side accept.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    load       = 1'b0;
    last_acc   = 1'b0;
    rsp_accept = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rsp_accept = 1'b1;
        if (bus.rsp_vld) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (byte_acc) begin
          if (idx_q == RSP_FRAME_LAST_IDX) begin
            // Last byte leaving: the slot frees this cycle, so a waiting response
            // can be taken now and start the next frame with no bubble.
            last_acc   = 1'b1;
            rsp_accept = 1'b1;
            idx_d      = '0;
            if (bus.rsp_vld) load = 1'b1;
            else             state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
    endcase
  end

  // FSM, byte index, busy flag and completed-frame counter.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      busy_r        <= 1'b0;
      frames_sent_r <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_r  <= (state_d == ST_SEND);
      if (last_acc) frames_sent_r <= frames_sent_r + 16'd1;
    end
  end

  // Holding register: captures the response on each accepted handshake.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: data-only register is still reset so an abandoned frame leaves nothing stale.
    if (rst)       hold_q <= '0;
    else if (load) hold_q <= bus.rsp;
  end

`ifdef OB_RSP_EGRESS_CHECKSUM_EN
  logic [7:0] csum_q;

  // Running XOR of the bytes accepted so far; restarts with each new frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           csum_q <= '0;
    else if (load)     csum_q <= '0;
    else if (byte_acc) csum_q <= csum_q ^ frame_byte;
  end

  assign frame_byte = (idx_q == RSP_FRAME_LAST_IDX) ? csum_q : mux_byte;
`else
  assign frame_byte = mux_byte;
`endif

  assign bus.rsp_accept = rsp_accept;
  assign bus.out_vld    = out_vld;
  assign bus.out_data   = out_vld ? frame_byte : 8'h00;
  assign bus.out_sop    = out_vld && (idx_q == '0);
  assign bus.out_eop    = out_vld && (idx_q == RSP_FRAME_LAST_IDX);

endmodule
